// File: rtl/store4_loader.sv
// rtl/store4_loader.sv - column-at-a-time write sequencer for the store4 2x2 latch array
// Each strobe is framed by setup/hold windows so row data never moves under a high strobe.
module store4_loader #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:3] in_data,
    input  logic [1:0] in_mask,
    output logic       dat0,
    output logic       dat1,
    output logic       cap0,
    output logic       cap1,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

    localparam int CW = $clog2(256);
    localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYC - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_col;
    logic          r_col1_pending;
    logic [1:0]    r_col1_data;
    logic          r_in_ready;
    logic          r_dat0;
    logic          r_dat1;
    logic          r_cap0;
    logic          r_cap1;
    logic          r_busy;
    logic          r_done;

    // Column 0 is written first whenever it is enabled.
    logic w_first_col;
    assign w_first_col = ~in_mask[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_col          <= 1'b0;
            r_col1_pending <= 1'b0;
            r_col1_data    <= 2'b00;
            r_in_ready     <= 1'b1;
            r_dat0         <= 1'b0;
            r_dat1         <= 1'b0;
            r_cap0         <= 1'b0;
            r_cap1         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_mask == 2'b00) begin
                            r_done <= 1'b1;
                        end else begin
                            r_col          <= w_first_col;
                            r_col1_pending <= in_mask[0] & in_mask[1];
                            r_col1_data    <= {in_data[1], in_data[3]};
                            r_dat0         <= w_first_col ? in_data[1] : in_data[0];
                            r_dat1         <= w_first_col ? in_data[3] : in_data[2];
                            r_cnt          <= C_SETUP;
                            r_state        <= S_SETUP;
                            r_busy         <= 1'b1;
                            r_in_ready     <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_cap0  <= ~r_col;
                        r_cap1  <= r_col;
                        r_cnt   <= C_PULSE;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_cap0  <= 1'b0;
                        r_cap1  <= 1'b0;
                        r_cnt   <= C_HOLD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_col1_pending) begin
                        r_col          <= 1'b1;
                        r_col1_pending <= 1'b0;
                        r_dat0         <= r_col1_data[1];
                        r_dat1         <= r_col1_data[0];
                        r_cnt          <= C_SETUP;
                        r_state        <= S_SETUP;
                    end else begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_done     <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign dat0     = r_dat0;
    assign dat1     = r_dat1;
    assign cap0     = r_cap0;
    assign cap1     = r_cap1;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
